// File: rtl/dm_arbiter_if.sv
// Requester, lock and data-memory signals shared by dm_arbiter and its surroundings.
// slave = arbiter side; master = requesters plus memory side.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [2:0]        m0_size;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [31:0]       m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [2:0]        m1_size;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [31:0]       m1_rdata;
  logic              m1_err;

  logic [ADDR_W-1:0] dm_address;
  logic [31:0]       dm_data_in;
  logic [2:0]        dm_size;
  logic [31:0]       dm_data_out;

  modport slave (
    input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output dm_address, dm_data_in, dm_size,
    input  dm_data_out
  );

  modport master (
    output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  dm_address, dm_data_in, dm_size,
    output dm_data_out
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: gnt 1 cycle after sampled req, read data 1 cycle after gnt; losers hold req.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin ties (default: fixed priority, port 0 wins ties).
module dm_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              cmd_port_q, cmd_port_d;
  logic              cmd_we_q, cmd_we_d;
  logic [2:0]        cmd_size_q, cmd_size_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic              owner1_q, owner1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
  logic              ptr_q, ptr_d;
`endif

  logic lock_hold;
  logic pick1;
  logic want0;
  logic want1;
  logic issue;
  logic size_ok;

  always_comb begin
    state_d     = state_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_size_d  = cmd_size_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    owner1_d    = owner1_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef DM_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
    pick1       = ptr_q;
`else
    pick1       = 1'b0;
`endif
    // A locked owner beats port 0 outright; otherwise port 1 wins only alone or by tie policy.
    lock_hold = owner1_q & bus.m1_lock;
    want1     = bus.m1_req & (lock_hold | ~bus.m0_req | pick1);
    want0     = bus.m0_req & ~lock_hold;

    case (state_q)
      IDLE: begin
        if (!bus.m1_lock) owner1_d = 1'b0;
        if (want1 || want0) begin
          state_d    = ISSUE;
          cmd_port_d = want1;
          owner1_d   = want1;
`ifdef DM_ARB_ROUND_ROBIN_EN
          ptr_d      = ~want1;
`endif
          if (want1) begin
            cmd_we_d    = bus.m1_we;
            cmd_size_d  = bus.m1_size;
            cmd_addr_d  = bus.m1_addr;
            cmd_wdata_d = bus.m1_wdata;
          end else begin
            cmd_we_d    = bus.m0_we;
            cmd_size_d  = bus.m0_size;
            cmd_addr_d  = bus.m0_addr;
            cmd_wdata_d = bus.m0_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = IDLE;
        if (!cmd_we_q) begin
          if (cmd_port_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = bus.dm_data_out;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = bus.dm_data_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_size_q  <= 3'd0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      owner1_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_size_q  <= cmd_size_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      owner1_q    <= owner1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Reset landing mid-ISSUE must suppress the write at that same edge, so gate with it here.
  assign issue   = (state_q == ISSUE) && !reset;
  assign size_ok = cmd_size_q inside {3'd1, 3'd2, 3'd4};

  assign bus.dm_address = issue ? cmd_addr_q : '0;
  assign bus.dm_data_in = issue ? cmd_wdata_q : '0;
  assign bus.dm_size    = (issue && cmd_we_q && size_ok) ? cmd_size_q : 3'd0;

  assign bus.m0_gnt    = issue && !cmd_port_q;
  assign bus.m1_gnt    = issue && cmd_port_q;
  assign bus.m0_err    = issue && !cmd_port_q && cmd_we_q && !size_ok;
  assign bus.m1_err    = issue && cmd_port_q && cmd_we_q && !size_ok;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

endmodule
